// File: rtl/time_bar_ext_pkg.sv
// Shared types for the countdown progress bar: VGA bus layout, FSM
// encoding and default colours.
package time_bar_ext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_ELAPSED = 3'd4
  } tb_state_e;

  localparam int HCOUNT_W     = 11;
  localparam int VCOUNT_W     = 11;
  localparam int RGB_W        = 12;
  localparam int VGA_BUS_SIZE = HCOUNT_W + VCOUNT_W + 4 + RGB_W;

  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblank;
    logic                vblank;
    logic [RGB_W-1:0]    rgb;
  } vga_bus_t;

  localparam logic [RGB_W-1:0] DEF_BAR_COLOR    = 12'h4C0;
  localparam logic [RGB_W-1:0] DEF_BAR_BG_COLOR = 12'h333;
  localparam logic [RGB_W-1:0] DEF_WARN_COLOR   = 12'hF00;

endpackage

// File: rtl/time_bar_ext_counter.sv
// Countdown state machine: owns the ms prescaler, remaining length,
// warning blink and the IDLE/READY/RUNNING/PAUSED/ELAPSED sequencing.
module time_bar_counter
  import time_bar_ext_pkg::*;
#(
  parameter int BAR_WIDTH    = 800,
  parameter int MS_PER_PIXEL = 40,
  parameter int BONUS_PIXELS = 100,
  parameter int WARN_PIXELS  = 160,
  parameter int BLINK_MS     = 250,
  parameter int RW           = $clog2(BAR_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          module_en_i,
  input  logic          start_i,
  input  logic          pause_i,
  input  logic          add_time_i,
  input  logic          one_ms_tick_i,
  output logic [RW-1:0] remaining_o,
  output logic          blink_phase_o,
  output tb_state_e     state_o
);

  localparam int MW = $clog2(MS_PER_PIXEL + 1);
  localparam int BW = $clog2(BLINK_MS + 1);

  tb_state_e     state_q;
  logic [RW-1:0] remaining_q;
  logic [MW-1:0] ms_cnt_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  logic          ms_last;
  logic          blink_last;
  logic          dec;
  logic          warn;
  logic [31:0]   run_sum;
  logic [31:0]   add_sum;
  logic [RW-1:0] rem_run_d;
  logic [RW-1:0] rem_add_d;

  // Decrement and bonus are folded into one sum so a coincident pair clamps once.
  always_comb begin
    ms_last    = (ms_cnt_q == MW'(MS_PER_PIXEL - 1));
    blink_last = (blink_cnt_q == BW'(BLINK_MS - 1));
    dec        = one_ms_tick_i && ms_last && (remaining_q != '0);
    warn       = (32'(remaining_q) <= 32'(WARN_PIXELS));
    run_sum    = 32'(remaining_q) - (dec ? 32'd1 : 32'd0)
               + (add_time_i ? 32'(BONUS_PIXELS) : 32'd0);
    add_sum    = 32'(remaining_q) + (add_time_i ? 32'(BONUS_PIXELS) : 32'd0);
    rem_run_d  = (run_sum > 32'(BAR_WIDTH)) ? RW'(BAR_WIDTH) : RW'(run_sum);
    rem_add_d  = (add_sum > 32'(BAR_WIDTH)) ? RW'(BAR_WIDTH) : RW'(add_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      ms_cnt_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (!module_en_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_READY;
          remaining_q <= RW'(BAR_WIDTH);
        end
        ST_READY: begin
          if (start_i) begin
            state_q       <= ST_RUNNING;
            ms_cnt_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
          end
        end
        ST_RUNNING, ST_PAUSED: begin
          if (start_i) begin
            state_q       <= pause_i ? ST_PAUSED : ST_RUNNING;
            remaining_q   <= RW'(BAR_WIDTH);
            ms_cnt_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
          end else if (state_q == ST_PAUSED) begin
            remaining_q <= rem_add_d;
            if (!pause_i) state_q <= ST_RUNNING;
          end else if (remaining_q == '0) begin
            state_q <= ST_ELAPSED;
          end else begin
            if (one_ms_tick_i) begin
              ms_cnt_q <= ms_last ? '0 : ms_cnt_q + MW'(1);
              if (warn) begin
                blink_cnt_q <= blink_last ? '0 : blink_cnt_q + BW'(1);
                if (blink_last) blink_phase_q <= ~blink_phase_q;
              end
            end
            remaining_q <= rem_run_d;
            if (pause_i) state_q <= ST_PAUSED;
          end
        end
        ST_ELAPSED: begin
          if (start_i) begin
            state_q     <= ST_READY;
            remaining_q <= RW'(BAR_WIDTH);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign remaining_o   = remaining_q;
  assign blink_phase_o = blink_phase_q;
  assign state_o       = state_q;

endmodule

// File: rtl/time_bar_ext.sv
// VGA overlay stage drawing a shrinking countdown bar; every bus field is
// registered once so the stage adds exactly one cycle of latency.
module time_bar_ext
  import time_bar_ext_pkg::*;
#(
  parameter int               BAR_X        = 0,
  parameter int               BAR_Y        = 575,
  parameter int               BAR_WIDTH    = 800,
  parameter int               BAR_HEIGHT   = 25,
  parameter int               MS_PER_PIXEL = 40,
  parameter int               BONUS_PIXELS = 100,
  parameter int               WARN_PIXELS  = 160,
  parameter int               BLINK_MS     = 250,
  parameter logic [RGB_W-1:0] BAR_COLOR    = DEF_BAR_COLOR,
  parameter logic [RGB_W-1:0] BAR_BG_COLOR = DEF_BAR_BG_COLOR,
  parameter logic [RGB_W-1:0] WARN_COLOR   = DEF_WARN_COLOR
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               module_en,
  input  logic                               start,
  input  logic                               pause,
  input  logic                               add_time,
  input  logic                               one_ms_tick,
  input  vga_bus_t                           vga_bus_in,
  output vga_bus_t                           vga_bus_out,
  output logic                               elapsed,
  output logic [$clog2(BAR_WIDTH + 1)-1:0]   remaining
);

  localparam int RW = $clog2(BAR_WIDTH + 1);

  logic [RW-1:0] rem_w;
  logic          blink_phase_w;
  tb_state_e     state_w;

  time_bar_counter #(
    .BAR_WIDTH    (BAR_WIDTH),
    .MS_PER_PIXEL (MS_PER_PIXEL),
    .BONUS_PIXELS (BONUS_PIXELS),
    .WARN_PIXELS  (WARN_PIXELS),
    .BLINK_MS     (BLINK_MS),
    .RW           (RW)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .module_en_i   (module_en),
    .start_i       (start),
    .pause_i       (pause),
    .add_time_i    (add_time),
    .one_ms_tick_i (one_ms_tick),
    .remaining_o   (rem_w),
    .blink_phase_o (blink_phase_w),
    .state_o       (state_w)
  );

  int               dx;
  int               dy;
  logic             in_bar;
  logic             filled;
  logic             warn_on;
  logic [RGB_W-1:0] fill_color;
  logic [RGB_W-1:0] rgb_d;
  vga_bus_t         bus_q;

  // Offsets are signed so a pixel left of / above the bar is simply negative.
  always_comb begin
    dx         = int'(vga_bus_in.hcount) - BAR_X;
    dy         = int'(vga_bus_in.vcount) - BAR_Y;
    in_bar     = (dx >= 0) && (dx < BAR_WIDTH) && (dy >= 0) && (dy < BAR_HEIGHT);
    filled     = (dx < int'(rem_w));
    warn_on    = blink_phase_w && (int'(rem_w) <= WARN_PIXELS);
    fill_color = warn_on ? WARN_COLOR : BAR_COLOR;
    rgb_d      = vga_bus_in.rgb;
    if (in_bar) begin
      case (state_w)
        ST_READY:   rgb_d = BAR_COLOR;
        ST_RUNNING: rgb_d = filled ? fill_color : BAR_BG_COLOR;
        ST_PAUSED:  rgb_d = filled ? BAR_COLOR : BAR_BG_COLOR;
        ST_ELAPSED: rgb_d = BAR_BG_COLOR;
        default:    rgb_d = vga_bus_in.rgb;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
    end else begin
      bus_q     <= vga_bus_in;
      bus_q.rgb <= rgb_d;
    end
  end

  assign vga_bus_out = bus_q;
  assign elapsed     = (state_w == ST_ELAPSED);
  assign remaining   = rem_w;

endmodule

// File: tb/tb_time_bar_ext.sv
// Self-checking bench for time_bar_ext: directed steps plus a randomized
// phase, all checked cycle by cycle against a behavioural model.
module tb_time_bar_ext;
  import time_bar_ext_pkg::*;

  localparam int W     = 800;
  localparam int X0    = 0;
  localparam int Y0    = 575;
  localparam int H     = 25;
  localparam int MS    = 2;
  localparam int BONUS = 100;
  localparam int WARN  = 160;
  localparam int BLINK = 4;
  localparam logic [11:0] C_BAR  = 12'h4C0;
  localparam logic [11:0] C_BG   = 12'h333;
  localparam logic [11:0] C_WARN = 12'hF00;

  logic clk = 1'b0;
  logic rst, en, start, pause, add, tick;
  vga_bus_t bin, bout;
  logic elapsed;
  logic [$clog2(W+1)-1:0] remaining;

  always #5 clk = ~clk;

  time_bar_ext #(
    .MS_PER_PIXEL (MS),
    .BLINK_MS     (BLINK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .module_en   (en),
    .start       (start),
    .pause       (pause),
    .add_time    (add),
    .one_ms_tick (tick),
    .vga_bus_in  (bin),
    .vga_bus_out (bout),
    .elapsed     (elapsed),
    .remaining   (remaining)
  );

  typedef enum {M_OFF, M_FULL, M_COUNT, M_HOLD, M_DONE} mode_e;
  mode_e m_mode;
  int    m_rem, m_ms, m_bc;
  bit    m_ph;
  bit    rand_pix;
  int    vectors, miscompares;
  logic [$bits(vga_bus_t)-1:0] exp_q[$];

  function automatic int clamp(int v);
    return (v > W) ? W : v;
  endfunction

  function automatic vga_bus_t model_pixel(vga_bus_t b);
    vga_bus_t o = b;
    int dx = int'(b.hcount) - X0;
    int dy = int'(b.vcount) - Y0;
    bit inb = (dx >= 0) && (dx < W) && (dy >= 0) && (dy < H);
    bit filled = dx < m_rem;
    if (inb) begin
      case (m_mode)
        M_FULL:  o.rgb = C_BAR;
        M_COUNT: o.rgb = filled ? ((m_ph && m_rem <= WARN) ? C_WARN : C_BAR) : C_BG;
        M_HOLD:  o.rgb = filled ? C_BAR : C_BG;
        M_DONE:  o.rgb = C_BG;
        default: o.rgb = b.rgb;
      endcase
    end
    return o;
  endfunction

  task automatic model_restart();
    m_rem = W; m_ms = 0; m_bc = 0; m_ph = 0;
    m_mode = pause ? M_HOLD : M_COUNT;
  endtask

  task automatic model_step();
    int dec;
    if (rst) begin
      m_mode = M_OFF; m_rem = 0; m_ms = 0; m_bc = 0; m_ph = 0;
    end else if (!en) begin
      m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF: begin m_mode = M_FULL; m_rem = W; end
        M_FULL: if (start) begin m_mode = M_COUNT; m_ms = 0; m_bc = 0; m_ph = 0; end
        M_COUNT: begin
          if (start) model_restart();
          else if (m_rem == 0) m_mode = M_DONE;
          else begin
            dec = 0;
            if (tick) begin
              m_ms++;
              if (m_ms == MS) begin m_ms = 0; dec = 1; end
              if (m_rem <= WARN) begin
                m_bc++;
                if (m_bc == BLINK) begin m_bc = 0; m_ph = !m_ph; end
              end
            end
            m_rem = clamp(m_rem - dec + (add ? BONUS : 0));
            if (pause) m_mode = M_HOLD;
          end
        end
        M_HOLD: begin
          if (start) model_restart();
          else begin
            m_rem = clamp(m_rem + (add ? BONUS : 0));
            if (!pause) m_mode = M_COUNT;
          end
        end
        M_DONE: if (start) begin m_mode = M_FULL; m_rem = W; end
        default: m_mode = M_OFF;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [$bits(vga_bus_t)-1:0] e;
    if (rand_pix) begin
      bin.hcount = 11'($urandom_range(0, 1000));
      bin.vcount = 11'($urandom_range(560, 610));
      bin.hsync  = 1'($urandom);
      bin.vsync  = 1'($urandom);
      bin.hblank = 1'($urandom);
      bin.vblank = 1'($urandom);
      bin.rgb    = 12'($urandom);
    end
    exp_q.push_back(rst ? '0 : model_pixel(bin));
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("bus", bout, e);
    check("remaining", remaining, m_rem);
    check("elapsed", elapsed, (m_mode == M_DONE));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic fix_pixel(input int hc, input int vc);
    rand_pix   = 1'b0;
    bin.hcount = 11'(hc);
    bin.vcount = 11'(vc);
    bin.rgb    = 12'($urandom);
  endtask

  initial begin
    vectors = 0; miscompares = 0; rand_pix = 1'b1;
    rst = 1'b1; en = 1'b0; start = 1'b0; pause = 1'b0; add = 1'b0; tick = 1'b0;
    bin = '0;
    m_mode = M_OFF; m_rem = 0; m_ms = 0; m_bc = 0; m_ph = 0;
    run(3);
    check("rst_out", bout, 64'd0);
    rst = 1'b0; en = 1'b1;
    run(1);
    check("ready_rem", remaining, W);
    fix_pixel(0, 580); run(1);
    check("ready_px", bout.rgb, C_BAR);
    fix_pixel(0, 574); run(1);
    check("above_px", bout.rgb, bin.rgb);
    rand_pix = 1'b1;

    pulse_start();
    tick = 1'b1; run(MS); tick = 1'b0;
    check("first_px", remaining, W - 1);

    tick = 1'b1;
    for (int i = 0; i < 2000 && remaining != 0; i++) cycle();
    tick = 1'b0;
    check("reach_zero", remaining, 0);
    run(1);
    check("elapsed_hi", elapsed, 1);
    fix_pixel(5, 580); run(1);
    check("done_px", bout.rgb, C_BG);
    rand_pix = 1'b1;

    pulse_start();
    check("rearm_rem", remaining, W);
    check("rearm_el", elapsed, 0);
    pulse_start();

    tick = 1'b1; run(100); tick = 1'b0;
    check("rem_750", remaining, 750);
    add = 1'b1; run(1); add = 1'b0;
    check("clamp", remaining, W);
    tick = 1'b1; run(1000);
    check("rem_300", remaining, 300);
    run(1);
    add = 1'b1; run(1); add = 1'b0; tick = 1'b0;
    check("dec_add", remaining, 399);

    pause = 1'b1; run(1);
    tick = 1'b1; run(50); tick = 1'b0;
    check("pause_hold", remaining, 399);
    pause = 1'b0; run(1);
    tick = 1'b1; run(MS); tick = 1'b0;
    check("resume", remaining, 398);

    tick = 1'b1; run(476); tick = 1'b0;
    check("warn_edge", remaining, WARN);
    fix_pixel(0, 580);
    tick = 1'b1; run(BLINK); tick = 1'b0; run(1);
    check("blink_on", bout.rgb, C_WARN);
    tick = 1'b1; run(BLINK); tick = 1'b0; run(1);
    check("blink_off", bout.rgb, C_BAR);

    en = 1'b0; run(1);
    check("en_off_el", elapsed, 0);
    run(1);
    check("idle_pass", bout.rgb, bin.rgb);
    rand_pix = 1'b1;
    en = 1'b1; run(1);
    pulse_start();
    tick = 1'b1; run(10); tick = 1'b0;
    rst = 1'b1; run(1); rst = 1'b0;
    check("rst_rem", remaining, 0);
    check("rst_bus", bout, 64'd0);

    for (int i = 0; i < 6000; i++) begin
      rst   = ($urandom_range(0, 1999) == 0);
      en    = ($urandom_range(0, 999) != 0);
      start = ($urandom_range(0, 2999) == 0) || (i == 2);
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      add   = ($urandom_range(0, 599) == 0);
      tick  = 1'($urandom);
      cycle();
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0; add = 1'b0; tick = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
